mem_arbiter: RTL and testbench

//  Shares the single physical memory port (read/write/byte_enable/address/wdata, resp/rdata) between
//  an instruction-fetch requester (I, read-only) and a data requester (D, read/write). Sits between the
//  cpu's split fetch/data paths and the memory model. Serializes one transaction at a time, registers
//  the outgoing request so memory sees stable signals, and routes the response back to the grantee.

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// Holds the FSM state and grant-port enumerations.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } arb_state_t;

  typedef enum logic {
    ARB_I,
    ARB_D
  } arb_port_t;

  localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one memory port between instruction fetch and data paths.
// Requests are registered on grant; responses route back to the grantee.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter bit RR_EN          = 1'b1,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int TO_W           = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_read,
  input  logic [31:0] i_address,
  output logic        i_resp,
  output logic [31:0] i_rdata,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [3:0]  d_byte_enable,
  input  logic [31:0] d_address,
  input  logic [31:0] d_wdata,
  output logic        d_resp,
  output logic [31:0] d_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic        mem_resp,
  input  logic [31:0] mem_rdata,
  output logic        timeout_err
);

  localparam logic [TO_W:0] TO_LIM = (TO_W+1)'(TIMEOUT_CYCLES);

  arb_state_t      state;
  arb_state_t      state_nxt;
  arb_port_t       last_grant;
  logic [TO_W-1:0] to_cnt;
  logic [TO_W:0]   cnt_inc;
  logic            d_pend;
  logic            busy;
  logic            grant_i;
  logic            grant_d;
  logic            expire;

  assign d_pend  = d_read | d_write;
  assign busy    = (state == BUSY_I) || (state == BUSY_D);
  assign cnt_inc = {1'b0, to_cnt} + (TO_W+1)'(1);

  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    expire    = 1'b0;
    case (state)
      IDLE: begin
        if (d_pend && (!i_read || !RR_EN || last_grant == ARB_I))
          grant_d = 1'b1;
        else if (i_read)
          grant_i = 1'b1;
        if (grant_d)
          state_nxt = BUSY_D;
        else if (grant_i)
          state_nxt = BUSY_I;
      end
      BUSY_I, BUSY_D: begin
        if (mem_resp) begin
          state_nxt = IDLE;
        end else if (TIMEOUT_CYCLES > 0 && cnt_inc >= TO_LIM) begin
          expire    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Capture registers: loaded only on grant so memory sees stable signals.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_byte_enable <= '0;
      mem_address     <= '0;
      mem_wdata       <= '0;
      last_grant      <= ARB_I;
      to_cnt          <= '0;
      timeout_err     <= 1'b0;
    end else begin
      if (grant_d) begin
        mem_read        <= ~d_write;
        mem_write       <= d_write;
        mem_byte_enable <= d_write ? d_byte_enable : BE_ALL;
        mem_address     <= d_address;
        mem_wdata       <= d_write ? d_wdata : '0;
        last_grant      <= ARB_D;
        to_cnt          <= '0;
      end else if (grant_i) begin
        mem_read        <= 1'b1;
        mem_write       <= 1'b0;
        mem_byte_enable <= BE_ALL;
        mem_address     <= i_address;
        mem_wdata       <= '0;
        last_grant      <= ARB_I;
        to_cnt          <= '0;
      end else if (busy && (mem_resp || expire)) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
      end else if (busy && to_cnt != '1) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (expire)
        timeout_err <= 1'b1;
    end
  end

  // A requester that has dropped its request gets no response.
  assign i_resp  = (state == BUSY_I) & mem_resp & i_read & ~rst;
  assign d_resp  = (state == BUSY_D) & mem_resp & d_pend & ~rst;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter.
// Round-robin/watchdog instance plus a fixed-priority instance.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_read, d_read, d_write;
  logic [31:0] i_address, d_address, d_wdata, mem_rdata;
  logic [3:0]  d_byte_enable;
  logic        mem_resp, mem_resp_fp;

  logic        i_resp, d_resp, mem_read, mem_write, timeout_err;
  logic [31:0] i_rdata, d_rdata, mem_address, mem_wdata;
  logic [3:0]  mem_byte_enable;

  logic        fp_i_resp, fp_d_resp, fp_mem_read, fp_mem_write, fp_timeout_err;
  logic [31:0] fp_i_rdata, fp_d_rdata, fp_mem_address, fp_mem_wdata;
  logic [3:0]  fp_mem_byte_enable;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.RR_EN(1'b1), .TIMEOUT_CYCLES(8), .TO_W(16)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address),
    .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write),
    .d_byte_enable(d_byte_enable), .d_address(d_address),
    .d_wdata(d_wdata), .d_resp(d_resp), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_resp(mem_resp),
    .mem_rdata(mem_rdata), .timeout_err(timeout_err)
  );

  mem_arbiter #(.RR_EN(1'b0), .TIMEOUT_CYCLES(0), .TO_W(16)) dut_fp (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address),
    .i_resp(fp_i_resp), .i_rdata(fp_i_rdata),
    .d_read(d_read), .d_write(d_write),
    .d_byte_enable(d_byte_enable), .d_address(d_address),
    .d_wdata(d_wdata), .d_resp(fp_d_resp), .d_rdata(fp_d_rdata),
    .mem_read(fp_mem_read), .mem_write(fp_mem_write),
    .mem_byte_enable(fp_mem_byte_enable), .mem_address(fp_mem_address),
    .mem_wdata(fp_mem_wdata), .mem_resp(mem_resp_fp),
    .mem_rdata(mem_rdata), .timeout_err(fp_timeout_err)
  );

  // Invariants on every cycle, plus the illegal read+write request.
  always @(negedge clk) begin
    checks++;
    if ((mem_read & mem_write) | (i_resp & d_resp) |
        (fp_mem_read & fp_mem_write) | (fp_i_resp & fp_d_resp) |
        (d_read & d_write))
      $display("FAIL invariant: rd/wr=%b%b resp=%b%b fp=%b%b%b%b dreq=%b%b",
               mem_read, mem_write, i_resp, d_resp, fp_mem_read,
               fp_mem_write, fp_i_resp, fp_d_resp, d_read, d_write);
    else
      passed++;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_in();
    i_read = 0; d_read = 0; d_write = 0;
    i_address = 0; d_address = 0; d_wdata = 0;
    d_byte_enable = 0; mem_rdata = 0;
    mem_resp = 0; mem_resp_fp = 0;
  endtask

  task automatic test_reset();
    rst = 1; clear_in();
    tick(); tick();
    checks++;
    if ({mem_read, mem_write, i_resp, d_resp, timeout_err} !== 5'b0)
      $display("FAIL reset_ctl: got %b want 00000",
               {mem_read, mem_write, i_resp, d_resp, timeout_err});
    else passed++;
    checks++;
    if ({mem_address, mem_wdata, mem_byte_enable} !== 68'h0)
      $display("FAIL reset_data: addr=%h wdata=%h be=%h want 0",
               mem_address, mem_wdata, mem_byte_enable);
    else passed++;
    rst = 0;
    tick();
  endtask

  task automatic test_i_only();
    i_read = 1; i_address = 32'h0000_0060;
    tick();
    checks++;
    if ({mem_read, mem_write} !== 2'b10 || mem_address !== 32'h60 ||
        mem_byte_enable !== 4'hF)
      $display("FAIL i_issue: rw=%b%b addr=%h be=%h want 10 60 f",
               mem_read, mem_write, mem_address, mem_byte_enable);
    else passed++;
    tick(); tick();
    checks++;
    if (i_resp !== 1'b0)
      $display("FAIL i_early_resp: got %b want 0", i_resp);
    else passed++;
    mem_resp = 1; mem_rdata = 32'hCAFE_0001;
    #1;
    checks++;
    if (i_resp !== 1'b1 || d_resp !== 1'b0 || i_rdata !== 32'hCAFE_0001)
      $display("FAIL i_resp: i=%b d=%b rdata=%h want 1 0 cafe0001",
               i_resp, d_resp, i_rdata);
    else passed++;
    tick();
    mem_resp = 0; i_read = 0;
    checks++;
    if (mem_read !== 1'b0)
      $display("FAIL i_strobe_drop: got %b want 0", mem_read);
    else passed++;
    tick();
  endtask

  task automatic test_d_write();
    d_write = 1; d_address = 32'h1000_0004;
    d_wdata = 32'hDEAD_BEEF; d_byte_enable = 4'b0011;
    tick();
    checks++;
    if ({mem_read, mem_write} !== 2'b01 || mem_address !== 32'h1000_0004 ||
        mem_wdata !== 32'hDEAD_BEEF || mem_byte_enable !== 4'b0011)
      $display("FAIL d_issue: rw=%b%b addr=%h wd=%h be=%h",
               mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable);
    else passed++;
    d_address = 32'hFFFF_FFFC;
    tick(); tick();
    checks++;
    if (mem_address !== 32'h1000_0004)
      $display("FAIL d_hold: addr=%h want 10000004", mem_address);
    else passed++;
    mem_resp = 1;
    #1;
    checks++;
    if ({i_resp, d_resp} !== 2'b01)
      $display("FAIL d_resp: i/d=%b want 01", {i_resp, d_resp});
    else passed++;
    tick();
    mem_resp = 0; d_write = 0;
    checks++;
    if (mem_write !== 1'b0)
      $display("FAIL d_strobe_drop: got %b want 0", mem_write);
    else passed++;
    tick();
  endtask

  task automatic test_drop();
    i_read = 1; i_address = 32'h44;
    tick();
    i_read = 0;
    tick();
    mem_resp = 1;
    #1;
    checks++;
    if (i_resp !== 1'b0)
      $display("FAIL drop_resp: got %b want 0", i_resp);
    else passed++;
    tick();
    mem_resp = 0;
    tick();
    checks++;
    if (mem_read !== 1'b0)
      $display("FAIL drop_idle: got %b want 0", mem_read);
    else passed++;
  endtask

  task automatic test_tie_rr();
    logic [3:0] exp_d;
    logic       is_d;
    exp_d = 4'b0101;
    rst = 1; tick(); rst = 0;
    i_read = 1; i_address = 32'h100;
    d_read = 1; d_address = 32'h200;
    for (int k = 0; k < 4; k++) begin
      is_d = exp_d[k];
      tick();
      checks++;
      if (mem_address !== (is_d ? 32'h200 : 32'h100))
        $display("FAIL rr_grant%0d: addr=%h want %h", k, mem_address,
                 is_d ? 32'h200 : 32'h100);
      else passed++;
      mem_resp = 1; mem_rdata = 32'(k);
      #1;
      checks++;
      if ({i_resp, d_resp} !== (is_d ? 2'b01 : 2'b10))
        $display("FAIL rr_resp%0d: i/d=%b want %b", k, {i_resp, d_resp},
                 is_d ? 2'b01 : 2'b10);
      else passed++;
      tick();
      mem_resp = 0;
    end
    clear_in();
    tick();
  endtask

  task automatic test_watchdog();
    d_read = 1; d_address = 32'h300;
    tick();
    checks++;
    if (mem_read !== 1'b1 || timeout_err !== 1'b0)
      $display("FAIL wd_start: rd=%b err=%b want 1 0", mem_read, timeout_err);
    else passed++;
    for (int c = 2; c <= 8; c++) begin
      tick();
      checks++;
      if (mem_read !== 1'b1)
        $display("FAIL wd_hold%0d: rd=%b want 1", c, mem_read);
      else passed++;
    end
    tick();
    checks++;
    if (mem_read !== 1'b0 || timeout_err !== 1'b1)
      $display("FAIL wd_expire: rd=%b err=%b want 0 1", mem_read, timeout_err);
    else passed++;
    d_read = 0; mem_resp = 1;
    #1;
    checks++;
    if ({i_resp, d_resp} !== 2'b00)
      $display("FAIL wd_late_resp: i/d=%b want 00", {i_resp, d_resp});
    else passed++;
    tick();
    mem_resp = 0;
    checks++;
    if (mem_read !== 1'b0 || timeout_err !== 1'b1)
      $display("FAIL wd_idle: rd=%b err=%b want 0 1", mem_read, timeout_err);
    else passed++;
    i_read = 1; i_address = 32'h80;
    tick();
    checks++;
    if (mem_read !== 1'b1 || mem_address !== 32'h80)
      $display("FAIL wd_next: rd=%b addr=%h want 1 80", mem_read, mem_address);
    else passed++;
    mem_resp = 1;
    #1;
    checks++;
    if (i_resp !== 1'b1)
      $display("FAIL wd_next_resp: got %b want 1", i_resp);
    else passed++;
    tick();
    mem_resp = 0; i_read = 0;
    checks++;
    if (timeout_err !== 1'b1)
      $display("FAIL wd_sticky: err=%b want 1", timeout_err);
    else passed++;
    tick();
  endtask

  task automatic test_reset_mid();
    i_read = 1; i_address = 32'h400;
    tick();
    checks++;
    if (mem_read !== 1'b1 || mem_address !== 32'h400)
      $display("FAIL rm_issue: rd=%b addr=%h want 1 400", mem_read, mem_address);
    else passed++;
    rst = 1; d_read = 1; d_address = 32'h500; mem_resp = 1;
    #1;
    checks++;
    if (i_resp !== 1'b0)
      $display("FAIL rm_discard: i_resp=%b want 0", i_resp);
    else passed++;
    tick();
    rst = 0; mem_resp = 0;
    checks++;
    if ({mem_read, mem_write, timeout_err, i_resp, d_resp} !== 5'b0 ||
        mem_address !== 32'h0)
      $display("FAIL rm_cleared: ctl=%b addr=%h want 0 0",
               {mem_read, mem_write, timeout_err, i_resp, d_resp}, mem_address);
    else passed++;
    tick();
    checks++;
    if (mem_read !== 1'b1 || mem_address !== 32'h500)
      $display("FAIL rm_tie_d: rd=%b addr=%h want 1 500", mem_read, mem_address);
    else passed++;
    mem_resp = 1;
    #1;
    checks++;
    if ({i_resp, d_resp} !== 2'b01)
      $display("FAIL rm_resp: i/d=%b want 01", {i_resp, d_resp});
    else passed++;
    tick();
    clear_in();
    tick();
  endtask

  task automatic test_fixed_prio();
    rst = 1; clear_in(); tick(); rst = 0;
    i_read = 1; i_address = 32'h600;
    d_read = 1; d_address = 32'h700;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (fp_mem_address !== 32'h700)
        $display("FAIL fp_grant%0d: addr=%h want 700", k, fp_mem_address);
      else passed++;
      mem_resp_fp = 1;
      #1;
      checks++;
      if ({fp_i_resp, fp_d_resp} !== 2'b01)
        $display("FAIL fp_resp%0d: i/d=%b want 01", k, {fp_i_resp, fp_d_resp});
      else passed++;
      tick();
      mem_resp_fp = 0;
      if (k == 3) d_read = 0;
    end
    tick();
    checks++;
    if (fp_mem_address !== 32'h600 || fp_mem_read !== 1'b1)
      $display("FAIL fp_i_after: rd=%b addr=%h want 1 600",
               fp_mem_read, fp_mem_address);
    else passed++;
    mem_resp_fp = 1;
    #1;
    checks++;
    if ({fp_i_resp, fp_d_resp} !== 2'b10)
      $display("FAIL fp_i_resp: i/d=%b want 10", {fp_i_resp, fp_d_resp});
    else passed++;
    tick();
    clear_in();
    tick();
  endtask

  initial begin
    clear_in();
    test_reset();
    test_i_only();
    test_d_write();
    test_drop();
    test_tie_rr();
    test_watchdog();
    test_reset_mid();
    test_fixed_prio();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
